// File: rtl/r_response_arbiter_if.sv
// AXI R-channel bundle between NUM_SRC response producers and the response FIFO.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface r_response_arbiter_if #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned ID_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned RESP_WIDTH = 2
);
   logic [NUM_SRC-1:0]            src_valid;
   logic [NUM_SRC-1:0]            src_ready;
   logic [NUM_SRC*ID_WIDTH-1:0]   src_id;
   logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
   logic [NUM_SRC*RESP_WIDTH-1:0] src_resp;
   logic [NUM_SRC-1:0]            src_last;

   logic                          out_valid;
   logic                          out_ready;
   logic [ID_WIDTH-1:0]           out_id;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [RESP_WIDTH-1:0]         out_resp;
   logic                          out_last;

   modport master (
      input  src_valid, src_id, src_data, src_resp, src_last, out_ready,
      output src_ready, out_valid, out_id, out_data, out_resp, out_last
   );

   modport slave (
      output src_valid, src_id, src_data, src_resp, src_last, out_ready,
      input  src_ready, out_valid, out_id, out_data, out_resp, out_last
   );
endinterface

// File: rtl/r_response_arbiter.sv
// Round-robin, burst-locked arbiter sharing one AXI R path between NUM_SRC sources.
// Grant is held until the owner's last beat is accepted; over-length bursts are flagged.
module r_response_arbiter #(
   parameter  int unsigned NUM_SRC    = 4,
   parameter  int unsigned ID_WIDTH   = 32,
   parameter  int unsigned DATA_WIDTH = 64,
   parameter  int unsigned RESP_WIDTH = 2,
   parameter  int unsigned MAX_BEATS  = 256,
   localparam int unsigned IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int unsigned BCNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   r_response_arbiter_if.master bus,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 lock_active,
   output logic [BCNT_W-1:0]    burst_beats,
   output logic                 err_overrun
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]        state, state_nxt;
   logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]  owner_q, owner_nxt;
   logic [BCNT_W-1:0] beats_nxt;
   logic              err_nxt;
   logic [IDX_W-1:0]  sel, cand;
   logic              accept, end_burst;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NUM_SRC - 1)) ? '0 : idx + IDX_W'(1);
   endfunction

   // Selection, zero-latency mux, next-state and burst bookkeeping
   always_comb begin
      sel           = rr_ptr;
      cand          = '0;
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      owner_nxt     = owner_q;
      beats_nxt     = burst_beats;
      err_nxt       = err_overrun;
      bus.src_ready = '0;
      bus.out_valid = 1'b0;
      bus.out_id    = '0;
      bus.out_data  = '0;
      bus.out_resp  = '0;
      bus.out_last  = 1'b0;

      // Locked owner wins outright; otherwise scan from rr_ptr, falling back to rr_ptr
      if (state == ST_LOCKED) begin
         sel = owner_q;
      end else begin
         for (int unsigned i = NUM_SRC; i > 0; i--) begin
            cand = IDX_W'((32'(rr_ptr) + i - 1) % NUM_SRC);
            if (bus.src_valid[cand]) sel = cand;
         end
      end

      if (!rst) begin
         bus.out_valid  = bus.src_valid[sel];
         bus.out_id     = bus.src_id[32'(sel)*ID_WIDTH +: ID_WIDTH];
         bus.out_data   = bus.src_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
         bus.out_resp   = bus.src_resp[32'(sel)*RESP_WIDTH +: RESP_WIDTH];
         bus.out_last   = bus.src_last[sel];
         bus.src_ready[sel] = bus.out_ready;
      end

      accept    = bus.out_valid & bus.out_ready;
      end_burst = accept & bus.out_last;

      case (state)
         ST_IDLE: begin
            if (end_burst) begin
               rr_ptr_nxt = next_idx(sel);
            end else if (bus.out_valid) begin
               state_nxt = ST_LOCKED;
               owner_nxt = sel;
            end
         end
         default: begin
            if (end_burst) begin
               state_nxt  = ST_IDLE;
               rr_ptr_nxt = next_idx(owner_q);
            end
         end
      endcase

      // Counter saturates; the overrun flag fires on the beat past the legal length
      if (end_burst) begin
         beats_nxt = '0;
      end else if (accept) begin
         if (burst_beats == BCNT_W'(MAX_BEATS - 1)) err_nxt = 1'b1;
         if (burst_beats != BCNT_W'(MAX_BEATS)) beats_nxt = burst_beats + BCNT_W'(1);
      end

      grant_idx   = sel;
      lock_active = (state == ST_LOCKED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         owner_q     <= '0;
         burst_beats <= '0;
         err_overrun <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         owner_q     <= owner_nxt;
         burst_beats <= beats_nxt;
         err_overrun <= err_nxt;
      end
   end

endmodule

// File: tb/tb_r_response_arbiter.sv
// Directed bench for r_response_arbiter with MAX_BEATS=4 so over-length bursts stay short.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_r_response_arbiter;

   localparam int unsigned NUM_SRC    = 4;
   localparam int unsigned ID_WIDTH   = 8;
   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned RESP_WIDTH = 2;
   localparam int unsigned MAX_BEATS  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant_idx;
   logic       lock_active;
   logic [2:0] burst_beats;
   logic       err_overrun;
   int         n_cmp  = 0;
   int         n_fail = 0;

   r_response_arbiter_if #(
      .NUM_SRC(NUM_SRC), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .RESP_WIDTH(RESP_WIDTH)
   ) bus ();

   r_response_arbiter #(
      .NUM_SRC(NUM_SRC), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .RESP_WIDTH(RESP_WIDTH), .MAX_BEATS(MAX_BEATS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .grant_idx(grant_idx),
      .lock_active(lock_active),
      .burst_beats(burst_beats),
      .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Source i carries id 0x10+i and resp i, so the muxed id/resp identify the winner
   task automatic src(input int i, input logic v, input logic l, input logic [15:0] d);
      bus.src_valid[i]                   = v;
      bus.src_last[i]                    = l;
      bus.src_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
      bus.src_id[i*ID_WIDTH +: ID_WIDTH]       = 8'(8'h10 + i);
      bus.src_resp[i*RESP_WIDTH +: RESP_WIDTH] = 2'(i);
   endtask

   task automatic all_idle();
      for (int i = 0; i < 4; i++) src(i, 1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      // 1. Reset with every source valid
      rst = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) src(i, 1'b1, 1'b1, 16'(16'h0100 + i));
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_src_ready", bus.src_ready, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_id", bus.out_id, 0);
      chk("rst_lock", lock_active, 0);
      chk("rst_beats", burst_beats, 0);
      chk("rst_err", err_overrun, 0);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("first_grant", grant_idx, 0);
      chk("first_src_ready", bus.src_ready, 4'b0001);
      chk("first_out_id", bus.out_id, 8'h10);

      // 2. Four single-beat sources served back-to-back: 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr_grant_%0d", k), grant_idx, k % 4);
         chk($sformatf("rr_data_%0d", k), bus.out_data, 16'h0100 + (k % 4));
         chk($sformatf("rr_resp_%0d", k), bus.out_resp, k % 4);
         chk($sformatf("rr_lock_%0d", k), lock_active, 0);
         tick();
      end
      all_idle();
      #1;
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_grant_rr", grant_idx, 1);

      // 3. Four-beat burst from source 1; source 0 arrives mid-burst and must wait
      src(1, 1'b1, 1'b0, 16'h00A1);
      #1;
      chk("b_grant_a", grant_idx, 1);
      chk("b_data_a", bus.out_data, 16'h00A1);
      tick();
      src(1, 1'b1, 1'b0, 16'h00A2);
      src(0, 1'b1, 1'b1, 16'h00B0);
      #1;
      chk("b_lock_b", lock_active, 1);
      chk("b_grant_b", grant_idx, 1);
      chk("b_ready_b", bus.src_ready, 4'b0010);
      chk("b_data_b", bus.out_data, 16'h00A2);
      chk("b_beats_b", burst_beats, 1);
      tick();
      src(1, 1'b1, 1'b0, 16'h00A3);
      #1;
      chk("b_grant_c", grant_idx, 1);
      chk("b_beats_c", burst_beats, 2);
      tick();
      src(1, 1'b1, 1'b1, 16'h00A4);
      #1;
      chk("b_grant_d", grant_idx, 1);
      chk("b_data_d", bus.out_data, 16'h00A4);
      chk("b_last_d", bus.out_last, 1);
      chk("b_beats_d", burst_beats, 3);
      tick();
      src(1, 1'b0, 1'b0, 16'h0);
      #1;
      chk("b_after_lock", lock_active, 0);
      chk("b_after_grant", grant_idx, 0);
      chk("b_after_beats", burst_beats, 0);
      chk("b_after_ready", bus.src_ready, 4'b0001);
      tick();
      all_idle();

      // 4. Stalled beat from source 2 holds the grant though source 0 becomes valid
      bus.out_ready = 1'b0;
      src(2, 1'b1, 1'b1, 16'h00C2);
      #1;
      chk("s_grant_1", grant_idx, 2);
      chk("s_valid_1", bus.out_valid, 1);
      chk("s_ready_1", bus.src_ready, 4'b0000);
      tick();
      src(0, 1'b1, 1'b1, 16'h00C0);
      #1;
      chk("s_grant_2", grant_idx, 2);
      chk("s_data_2", bus.out_data, 16'h00C2);
      chk("s_lock_2", lock_active, 1);
      tick();
      #1;
      chk("s_grant_3", grant_idx, 2);
      chk("s_id_3", bus.out_id, 8'h12);
      bus.out_ready = 1'b1;
      #1;
      chk("s_ready_4", bus.src_ready, 4'b0100);
      tick();
      src(2, 1'b0, 1'b0, 16'h0);
      #1;
      chk("s_next_grant", grant_idx, 0);
      chk("s_next_data", bus.out_data, 16'h00C0);
      tick();
      all_idle();

      // 5. Six-beat burst from source 3 overruns MAX_BEATS=4
      for (int b = 1; b <= 6; b++) begin
         src(3, 1'b1, (b == 6), 16'(16'h00D0 + b));
         #1;
         chk($sformatf("o_grant_%0d", b), grant_idx, 3);
         chk($sformatf("o_beats_%0d", b), burst_beats, (b - 1 > 4) ? 4 : b - 1);
         chk($sformatf("o_err_%0d", b), err_overrun, (b > 4));
         tick();
      end
      src(3, 1'b0, 1'b0, 16'h0);
      #1;
      chk("o_beats_end", burst_beats, 0);
      chk("o_err_sticky", err_overrun, 1);
      chk("o_lock_end", lock_active, 0);
      chk("o_rr_wrap", grant_idx, 0);

      // 6. Reset during beat 2 of a burst from source 1
      src(1, 1'b1, 1'b0, 16'h00E1);
      tick();
      src(1, 1'b1, 1'b0, 16'h00E2);
      #1;
      chk("r_lock_pre", lock_active, 1);
      chk("r_beats_pre", burst_beats, 1);
      rst = 1'b1;
      #1;
      chk("r_lock_rst", lock_active, 0);
      chk("r_ready_rst", bus.src_ready, 0);
      chk("r_valid_rst", bus.out_valid, 0);
      chk("r_err_rst", err_overrun, 0);
      tick();
      rst = 1'b0;
      src(0, 1'b1, 1'b1, 16'h00F0);
      src(1, 1'b1, 1'b1, 16'h00F1);
      #1;
      chk("r_restart_grant", grant_idx, 0);
      chk("r_restart_beats", burst_beats, 0);
      chk("r_restart_data", bus.out_data, 16'h00F0);
      tick();
      #1;
      chk("r_second_grant", grant_idx, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
